// File: rtl/zilla_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zilla_prefetch_queue                                         |
// | Description : Instruction prefetch queue between fetch and decode. Each    |
// |               entry holds an instruction/PC pair. Valid/ready handshakes   |
// |               are used on both sides. A redirect flushes the queue and     |
// |               then discards REDIRECT_DROP stale fetch responses. Debug     |
// |               halt freezes the queue and forces NOP onto decode.           |
// | Option      : define ZILLA_PREFETCH_BYPASS_EN to present fetch data to     |
// |               decode combinationally whenever the queue is empty.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   z_clk                      in   clock, rising edge                       |
// |   z_rst                      in   asynchronous active-high reset           |
// |   redirect_i                 in   branch/trap/mret/flush pulse             |
// |   debug_halt_i               in   debug halt level                         |
// |   fetch_valid_i              in   fetch response valid                     |
// |   fetch_ready_o              out  queue accepts a fetch response           |
// |   fetch_instruction_i        in   fetched instruction                      |
// |   fetch_pc_i                 in   PC of fetched instruction                |
// |   decode_instruction_valid_o out  head entry presented to decode           |
// |   decode_ready_i             in   decode accepts head entry                |
// |   decode_instruction_o       out  head instruction or NOP_INSN             |
// |   decode_pc_o                out  head PC or 0                             |
// |   count_o                    out  occupancy                                |
// |   drop_active_o              out  stale responses are being discarded      |
// +----------------------------------------------------------------------------+
module zilla_prefetch_queue #(
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter int                           PC_WIDTH          = 32,
  parameter int                           DEPTH             = 8,
  parameter int                           REDIRECT_DROP     = 2,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSN          = 'h0000_0013
) (
  input  logic                         z_clk,
  input  logic                         z_rst,
  input  logic                         redirect_i,
  input  logic                         debug_halt_i,
  input  logic                         fetch_valid_i,
  output logic                         fetch_ready_o,
  input  logic [INSTRUCTION_WIDTH-1:0] fetch_instruction_i,
  input  logic [PC_WIDTH-1:0]          fetch_pc_i,
  output logic                         decode_instruction_valid_o,
  input  logic                         decode_ready_i,
  output logic [INSTRUCTION_WIDTH-1:0] decode_instruction_o,
  output logic [PC_WIDTH-1:0]          decode_pc_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         drop_active_o
);

  localparam int         ADDR_W    = $clog2(DEPTH);
  localparam int         PTR_W     = ADDR_W + 1;
  localparam logic [2:0] DROP_LOAD = (REDIRECT_DROP > 0) ? 3'(REDIRECT_DROP - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2:0]         drop_cnt;
  logic [2:0]         drop_cnt_next;
  logic               started;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [ADDR_W-1:0]  waddr;
  logic [ADDR_W-1:0]  raddr;
  logic               full;
  logic               empty;
  logic               queue_valid;
  logic               push;
  logic               pop;
  logic               flush;
  logic               bypass_hit;
  logic               bypass_consume;

  logic [INSTRUCTION_WIDTH-1:0] mem_insn [DEPTH];
  logic [PC_WIDTH-1:0]          mem_pc   [DEPTH];

  assign waddr = wptr[ADDR_W-1:0];
  assign raddr = rptr[ADDR_W-1:0];
  assign full  = (waddr == raddr) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign empty = (wptr == rptr);

  assign count_o       = wptr - rptr;
  assign drop_active_o = (state == ST_DROP);

  // Halt outranks redirect, so a redirect seen while halted is ignored.
  assign flush = redirect_i && !debug_halt_i;

  // Head entry is only offered in RUN and is masked in the same cycle by
  // a redirect or a halt request.
  assign queue_valid = !empty && (state == ST_RUN) && !redirect_i && !debug_halt_i;
  assign pop         = queue_valid && decode_ready_i;

`ifdef ZILLA_PREFETCH_BYPASS_EN
  // Empty queue in RUN: forward the fetch response straight to decode.
  // If decode takes it this cycle the write is skipped entirely.
  assign bypass_hit     = empty && (state == ST_RUN) && !redirect_i &&
                          !debug_halt_i && fetch_valid_i;
  assign bypass_consume = bypass_hit && decode_ready_i;
`else
  assign bypass_hit     = 1'b0;
  assign bypass_consume = 1'b0;
`endif

  // Responses arriving in DROP, or in a redirect cycle, are acknowledged
  // but never written.
  assign push = fetch_valid_i && fetch_ready_o && !redirect_i && !debug_halt_i &&
                ((state == ST_IDLE) || (state == ST_RUN)) && !bypass_consume;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      state    <= ST_IDLE;
      drop_cnt <= 3'd0;
      started  <= 1'b0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_cnt_next;
      if ((state_next == ST_RUN) || (state_next == ST_DROP)) begin
        started <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    drop_cnt_next = drop_cnt;
    fetch_ready_o = 1'b0;

    case (state)
      ST_IDLE, ST_RUN: fetch_ready_o = !full;
      ST_DROP:         fetch_ready_o = 1'b1;
      default:         fetch_ready_o = 1'b0;
    endcase
    // Ready is held low while reset is asserted and for the whole of a halt
    // request, including the cycle it first appears.
    if (z_rst || debug_halt_i) begin
      fetch_ready_o = 1'b0;
    end

    if (debug_halt_i) begin
      state_next = ST_HALT;
    end else if (redirect_i) begin
      if (REDIRECT_DROP > 0) begin
        state_next    = ST_DROP;
        drop_cnt_next = DROP_LOAD;
      end else begin
        state_next = ST_RUN;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_valid_i) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          state_next = ST_RUN;
        end
        ST_DROP: begin
          if (drop_cnt == 3'd0) begin
            state_next = ST_RUN;
          end else begin
            drop_cnt_next = drop_cnt - 3'd1;
          end
        end
        default: begin
          // Leaving HALT: an unstarted queue goes back to waiting for the
          // first fetch response.
          state_next = started ? ST_RUN : ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage (not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge z_clk) begin
    if (push) begin
      mem_insn[waddr] <= fetch_instruction_i;
      mem_pc[waddr]   <= fetch_pc_i;
    end
  end

  // --------------------------------------------------------------------------
  // Decode outputs
  // --------------------------------------------------------------------------
  always_comb begin
    decode_instruction_valid_o = queue_valid;
    decode_instruction_o       = NOP_INSN;
    decode_pc_o                = '0;
    if (queue_valid) begin
      decode_instruction_o = mem_insn[raddr];
      decode_pc_o          = mem_pc[raddr];
    end
    if (bypass_hit) begin
      decode_instruction_valid_o = 1'b1;
      decode_instruction_o       = fetch_instruction_i;
      decode_pc_o                = fetch_pc_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zilla_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_zilla_prefetch_queue                                      |
// | Description : Directed self-checking bench for zilla_prefetch_queue at     |
// |               DEPTH=8, REDIRECT_DROP=2. Inputs change on the falling edge, |
// |               outputs are sampled 1ns later.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_zilla_prefetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ZILLA_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic        halt;
  logic        fvalid;
  logic        fready;
  logic [31:0] finsn;
  logic [31:0] fpc;
  logic        dvalid;
  logic        dready;
  logic [31:0] dinsn;
  logic [31:0] dpc;
  logic [3:0]  count;
  logic        drop_active;

  int checks;
  int passed;

  zilla_prefetch_queue dut (
    .z_clk                      (clk),
    .z_rst                      (rst),
    .redirect_i                 (redirect),
    .debug_halt_i               (halt),
    .fetch_valid_i              (fvalid),
    .fetch_ready_o              (fready),
    .fetch_instruction_i        (finsn),
    .fetch_pc_i                 (fpc),
    .decode_instruction_valid_o (dvalid),
    .decode_ready_i             (dready),
    .decode_instruction_o       (dinsn),
    .decode_pc_o                (dpc),
    .count_o                    (count),
    .drop_active_o              (drop_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; fvalid = 1'b0;
    finsn = '0; fpc = '0; dready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    checks++; if (fready !== 1'b0) $display("FAIL reset_fready got %b exp 0", fready); else passed++;
    checks++; if (dvalid !== 1'b0) $display("FAIL reset_dvalid got %b exp 0", dvalid); else passed++;
    checks++; if (dinsn !== NOP) $display("FAIL reset_dinsn got %h exp %h", dinsn, NOP); else passed++;
    checks++; if (dpc !== 32'h0) $display("FAIL reset_dpc got %h exp 0", dpc); else passed++;
    checks++; if (drop_active !== 1'b0) $display("FAIL reset_drop got %b exp 0", drop_active); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (fready !== 1'b1) $display("FAIL idle_fready got %b exp 1", fready); else passed++;
  endtask

  task automatic test_fill();
    dready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      fvalid = 1'b1; finsn = 32'h100 + i; fpc = 32'h1000 + 4 * i;
    end
    @(negedge clk);
    fvalid = 1'b1; finsn = 32'h108; fpc = 32'h1020;
    #1;
    checks++; if (count !== 4'd8) $display("FAIL fill_count got %0d exp 8", count); else passed++;
    checks++; if (fready !== 1'b0) $display("FAIL fill_fready got %b exp 0", fready); else passed++;
    checks++; if (dinsn !== 32'h100) $display("FAIL fill_head got %h exp 100", dinsn); else passed++;
    @(negedge clk);
    fvalid = 1'b0;
    #1;
    checks++; if (count !== 4'd8) $display("FAIL full_refuse_count got %0d exp 8", count); else passed++;
    checks++; if (dinsn !== 32'h100) $display("FAIL full_refuse_head got %h exp 100", dinsn); else passed++;
  endtask

  task automatic test_drain();
    @(negedge clk);
    dready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (dvalid !== 1'b1) $display("FAIL drain_valid[%0d] got %b exp 1", i, dvalid); else passed++;
      checks++; if (dinsn !== 32'h100 + i) $display("FAIL drain_insn[%0d] got %h exp %h", i, dinsn, 32'h100 + i); else passed++;
      checks++; if (dpc !== 32'h1000 + 4 * i) $display("FAIL drain_pc[%0d] got %h exp %h", i, dpc, 32'h1000 + 4 * i); else passed++;
      @(negedge clk);
    end
    #1;
    checks++; if (count !== 4'd0) $display("FAIL drain_count got %0d exp 0", count); else passed++;
    checks++; if (dvalid !== 1'b0) $display("FAIL drain_empty_valid got %b exp 0", dvalid); else passed++;
    checks++; if (dinsn !== NOP) $display("FAIL drain_empty_insn got %h exp %h", dinsn, NOP); else passed++;
    @(negedge clk);
    #1;
    checks++; if (count !== 4'd0) $display("FAIL empty_pop_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_stream();
    @(negedge clk);
    dready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fvalid = 1'b1; finsn = 32'h500 + k; fpc = 32'h5000 + 4 * k;
      #1;
      if (BYP) begin
        checks++; if (dinsn !== 32'h500 + k) $display("FAIL stream_insn[%0d] got %h exp %h", k, dinsn, 32'h500 + k); else passed++;
        checks++; if (count !== 4'd0) $display("FAIL stream_count[%0d] got %0d exp 0", k, count); else passed++;
      end else if (k > 0) begin
        checks++; if (dinsn !== 32'h500 + k - 1) $display("FAIL stream_insn[%0d] got %h exp %h", k, dinsn, 32'h500 + k - 1); else passed++;
        checks++; if (dpc !== 32'h5000 + 4 * (k - 1)) $display("FAIL stream_pc[%0d] got %h exp %h", k, dpc, 32'h5000 + 4 * (k - 1)); else passed++;
        checks++; if (count !== 4'd1) $display("FAIL stream_count[%0d] got %0d exp 1", k, count); else passed++;
      end
      @(negedge clk);
    end
    fvalid = 1'b0;
    #1;
    if (!BYP) begin
      checks++; if (dinsn !== 32'h513) $display("FAIL stream_last got %h exp 513", dinsn); else passed++;
    end
    @(negedge clk);
    #1;
    checks++; if (count !== 4'd0) $display("FAIL stream_end_count got %0d exp 0", count); else passed++;
  endtask

  task automatic test_redirect();
    dready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fvalid = 1'b1; finsn = 32'h200 + i; fpc = 32'h2000 + 4 * i;
      @(negedge clk);
    end
    fvalid = 1'b0;
    redirect = 1'b1;
    #1;
    checks++; if (dvalid !== 1'b0) $display("FAIL redir_mask_valid got %b exp 0", dvalid); else passed++;
    checks++; if (dinsn !== NOP) $display("FAIL redir_mask_insn got %h exp %h", dinsn, NOP); else passed++;
    checks++; if (count !== 4'd5) $display("FAIL redir_pre_count got %0d exp 5", count); else passed++;
    @(negedge clk);
    redirect = 1'b0;
    fvalid = 1'b1; finsn = 32'h300; fpc = 32'h3000;
    #1;
    checks++; if (count !== 4'd0) $display("FAIL redir_flush_count got %0d exp 0", count); else passed++;
    checks++; if (drop_active !== 1'b1) $display("FAIL redir_drop1 got %b exp 1", drop_active); else passed++;
    checks++; if (fready !== 1'b1) $display("FAIL redir_drop_fready got %b exp 1", fready); else passed++;
    @(negedge clk);
    finsn = 32'h301; fpc = 32'h3004;
    #1;
    checks++; if (drop_active !== 1'b1) $display("FAIL redir_drop2 got %b exp 1", drop_active); else passed++;
    @(negedge clk);
    finsn = 32'h302; fpc = 32'h3008;
    #1;
    checks++; if (drop_active !== 1'b0) $display("FAIL redir_run got %b exp 0", drop_active); else passed++;
    checks++; if (count !== 4'd0) $display("FAIL redir_discard_count got %0d exp 0", count); else passed++;
    @(negedge clk);
    fvalid = 1'b0;
    #1;
    checks++; if (count !== 4'd1) $display("FAIL redir_third_count got %0d exp 1", count); else passed++;
    checks++; if (dinsn !== 32'h302) $display("FAIL redir_third_insn got %h exp 302", dinsn); else passed++;
    checks++; if (dpc !== 32'h3008) $display("FAIL redir_third_pc got %h exp 3008", dpc); else passed++;
    dready = 1'b1;
    @(negedge clk);
    dready = 1'b0;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 3; i++) begin
      fvalid = 1'b1; finsn = 32'h400 + i; fpc = 32'h4000 + 4 * i;
      @(negedge clk);
    end
    halt = 1'b1; dready = 1'b1;
    fvalid = 1'b1; finsn = 32'h4FF; fpc = 32'h4FFC;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (dinsn !== NOP || dvalid !== 1'b0) $display("FAIL halt_mask[%0d] got %h/%b exp %h/0", i, dinsn, dvalid, NOP); else passed++;
      checks++; if (fready !== 1'b0) $display("FAIL halt_fready[%0d] got %b exp 0", i, fready); else passed++;
      @(negedge clk);
    end
    #1;
    checks++; if (count !== 4'd3) $display("FAIL halt_count got %0d exp 3", count); else passed++;
    halt = 1'b0; fvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dvalid !== 1'b1 || dinsn !== 32'h400 + i) $display("FAIL halt_release[%0d] got %h/%b exp %h/1", i, dinsn, dvalid, 32'h400 + i); else passed++;
      @(negedge clk);
    end
    #1;
    checks++; if (count !== 4'd0) $display("FAIL halt_end_count got %0d exp 0", count); else passed++;
  endtask

`ifdef ZILLA_PREFETCH_BYPASS_EN
  task automatic test_bypass();
    @(negedge clk);
    dready = 1'b1; fvalid = 1'b1; finsn = 32'h0000_ABCD; fpc = 32'h6000;
    #1;
    checks++; if (dvalid !== 1'b1 || dinsn !== 32'h0000_ABCD) $display("FAIL bypass_insn got %h/%b exp abcd/1", dinsn, dvalid); else passed++;
    @(negedge clk);
    fvalid = 1'b0;
    #1;
    checks++; if (count !== 4'd0) $display("FAIL bypass_count got %0d exp 0", count); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    dready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fvalid = 1'b1; finsn = 32'h700 + i; fpc = 32'h7000 + 4 * i;
      @(negedge clk);
    end
    fvalid = 1'b0;
    #1;
    checks++; if (count !== 4'd2) $display("FAIL mid_pre_count got %0d exp 2", count); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++; if (count !== 4'd0) $display("FAIL mid_rst_count got %0d exp 0", count); else passed++;
    checks++; if (dvalid !== 1'b0 || dinsn !== NOP) $display("FAIL mid_rst_decode got %h/%b exp %h/0", dinsn, dvalid, NOP); else passed++;
    checks++; if (fready !== 1'b0) $display("FAIL mid_rst_fready got %b exp 0", fready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (fready !== 1'b1) $display("FAIL mid_idle_fready got %b exp 1", fready); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_redirect();
    test_halt();
`ifdef ZILLA_PREFETCH_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zilla_prefetch_queue.md
Name: zilla_prefetch_queue

Overview:
- Parametrised successor to the fixed 5-entry instruction buffer; sits between the fetch unit and the decode stage.
- Generic-depth FIFO carrying an instruction/PC pair per entry, with a valid/ready handshake on both sides.
- Redirects (branch/trap/mret/flush) discard queued entries, then drop a configurable number of stale in-flight fetch responses.
- Debug halt freezes the queue and masks the decode output to NOP.

Parameters:
INSTRUCTION_WIDTH, 32, instruction width in bits
PC_WIDTH, 32, PC width carried alongside each instruction
DEPTH, 8, entry count; power of two, 2..64
REDIRECT_DROP, 2, cycles after a redirect during which fetch responses are discarded (0..7)
NOP_INSN, 32'h0000_0013, value driven on decode_instruction_o when not valid

Ports:
z_clk  input  1  clock, all state on rising edge
z_rst  input  1  asynchronous, active-high reset
redirect_i  input  1  branch | trap | mret | flush, single-cycle pulse
debug_halt_i  input  1  core in debug mode, level
fetch_valid_i  input  1  fetch response valid
fetch_ready_o  output  1  queue accepts a fetch response
fetch_instruction_i  input  INSTRUCTION_WIDTH  fetched instruction
fetch_pc_i  input  PC_WIDTH  PC of the fetched instruction
decode_instruction_valid_o  output  1  head entry presented to decode
decode_ready_i  input  1  decode accepts the head entry (low = stall)
decode_instruction_o  output  INSTRUCTION_WIDTH  head instruction, or NOP_INSN
decode_pc_o  output  PC_WIDTH  head PC, or 0
count_o  output  clog2(DEPTH)+1  occupancy
drop_active_o  output  1  FSM is in DROP

Behaviour:
- Reset (z_rst high, asynchronous):
  - Read/write pointers = 0, count_o = 0, FSM = IDLE, drop counter = 0.
  - fetch_ready_o = 0, decode_instruction_valid_o = 0, decode_instruction_o = NOP_INSN, decode_pc_o = 0, drop_active_o = 0.
  - Storage array is not reset.
- Pointers are clog2(DEPTH)+1 bits wide with a wrap bit.
  - full = (addresses equal) & (wrap bits differ); empty = pointers equal.
  - count_o = wptr - rptr, modulo width.
- FSM states:
  - IDLE: entered from reset. Goes to RUN on the first fetch_valid_i with debug_halt_i low; that response is pushed.
  - RUN: normal operation.
    - push = fetch_valid_i & fetch_ready_o.
    - pop = decode_instruction_valid_o & decode_ready_i.
    - push and pop may occur in the same cycle; count_o is unchanged.
  - DROP: entered on redirect_i from RUN or IDLE when REDIRECT_DROP > 0; otherwise go straight to RUN.
    - Drop counter loads REDIRECT_DROP-1.
    - fetch_ready_o = 1 and responses are accepted-and-discarded.
    - Goes to RUN when the counter is 0; the counter decrements each cycle.
    - A redirect_i while in DROP reloads the counter.
  - HALT: entered from any state while debug_halt_i = 1.
    - No push, no pop, contents retained, fetch_ready_o = 0.
    - On deassertion, returns to RUN (or IDLE if the queue was never started).
- fetch_ready_o = !full in RUN/IDLE; it is not relieved by a same-cycle pop.
- Read latency: an entry pushed at edge N is visible on decode outputs after edge N (one-cycle fetch-to-decode).
- decode_instruction_valid_o = !empty & state==RUN & !redirect_i & !debug_halt_i (combinational mask).
  - When low, outputs are NOP_INSN / 0.
- Redirect (redirect_i = 1):
  - Decode outputs are masked the same cycle.
  - At the next edge: rptr <= wptr (queue emptied) and count_o = 0.
  - Any push or pop in that cycle is cancelled.
- Precedence: z_rst > debug_halt_i > redirect_i > push/pop.
- Wrap-around: address bits roll over from DEPTH-1 to 0, and the wrap bit toggles.
- Full with push attempted: not accepted (fetch_ready_o = 0), and the data is not written.
- Empty with decode_ready_i high: no pop, and valid stays 0.
- Reset asserted mid-operation aborts everything, asynchronously, to the reset values above.

Optional Feature:
- Macro: ZILLA_PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, state is RUN, there is no redirect/halt, and fetch_valid_i = 1, fetch data is presented combinationally on the decode outputs with valid = 1 in the same cycle.
  - If decode_ready_i = 1, the entry is consumed without a write (pointers unchanged).
  - Otherwise it is written normally.
- Undefined: fetch-to-decode latency is always one cycle; there is no combinational path from fetch inputs to decode outputs.

Test Plan:
- Reset, then push 8 instructions (0x100..0x107) with decode_ready_i = 0 → count_o = 8, fetch_ready_o = 0; the 9th push is refused and count_o stays 8.
- Full queue, assert decode_ready_i for 8 cycles → decode outputs 0x100..0x107 in order with the matching PCs; count_o reaches 0 and valid drops to 0.
- Continuous push/pop for 20 entries at DEPTH = 8 → in-order delivery across two pointer wraps; count_o is constant at 1.
- Queue holding 5 entries, redirect_i pulse (REDIRECT_DROP = 2) → valid = 0 the same cycle, count_o = 0 next cycle; two fetch responses are discarded; the third response appears at decode.
- 3 entries queued, debug_halt_i high for 10 cycles with decode_ready_i = 1 → decode_instruction_o = 0x0000_0013, valid = 0, count_o stays 3; after release the same 3 entries are delivered.
- ZILLA_PREFETCH_BYPASS_EN defined, empty queue, fetch 0xABCD with decode_ready_i = 1 → decode_instruction_o = 0xABCD with valid = 1 in the same cycle, count_o stays 0.
